// File: rtl/insn_loader.sv
// Boot-time instruction-memory writer: takes a count header plus big-endian
// words from a byte stream, writes them from address 0, then releases the core.
module insn_loader #(
  parameter int LEN_INSN  = 32,
  parameter int LEN_ADDR  = 8,
  parameter int LEN_COUNT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byte_i,
  input  logic                valid_i,
  output logic                stall_o,
  output logic                mem_we_o,
  output logic [LEN_ADDR-1:0] mem_addr_o,
  output logic [LEN_INSN-1:0] mem_data_o,
  output logic                cpu_rst_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int HDR_B  = LEN_COUNT / 8;
  localparam int WORD_B = LEN_INSN / 8;
  localparam int MAXB   = (HDR_B > WORD_B) ? HDR_B : WORD_B;
  localparam int BW     = $clog2(MAXB + 1);
  // Common width for comparing the header count against depth and word index
  localparam int CW     = (LEN_COUNT > LEN_ADDR + 1) ? LEN_COUNT : LEN_ADDR + 1;

  typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

  state_t              r_state;
  logic [BW-1:0]       r_bcnt;
  logic [LEN_COUNT-1:0] r_count;
  logic [LEN_INSN-1:0] r_word;
  logic [LEN_ADDR:0]   r_idx;
  logic                r_we;
  logic [LEN_ADDR-1:0] r_addr;
  logic [LEN_INSN-1:0] r_data;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_err;

  logic                 w_accept;
  logic [LEN_COUNT-1:0] w_count_next;
  logic [LEN_INSN-1:0]  w_word_next;
  logic                 w_hdr_last;
  logic                 w_word_last;
  logic                 w_too_big;
  logic [LEN_ADDR:0]    w_idx_inc;
  logic                 w_last_word;

  assign stall_o      = rst || !(r_state == S_HDR || r_state == S_DATA);
  assign w_accept     = valid_i && !stall_o;
  assign w_count_next = (r_count << 8) | LEN_COUNT'(byte_i);
  assign w_word_next  = (r_word << 8) | LEN_INSN'(byte_i);
  assign w_hdr_last   = (r_bcnt == BW'(HDR_B - 1));
  assign w_word_last  = (r_bcnt == BW'(WORD_B - 1));
  assign w_too_big    = CW'(w_count_next) > (CW'(1) << LEN_ADDR);
  assign w_idx_inc    = r_idx + 1'b1;
  assign w_last_word  = (CW'(w_idx_inc) == CW'(r_count));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_HDR;
      r_bcnt    <= '0;
      r_count   <= '0;
      r_word    <= '0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_HDR: if (w_accept) begin
          r_count <= w_count_next;
          if (w_hdr_last) begin
            r_bcnt <= '0;
            if (w_count_next == '0) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else if (w_too_big) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        S_DATA: if (w_accept) begin
          r_word <= w_word_next;
          if (w_word_last) begin
            r_bcnt  <= '0;
            r_we    <= 1'b1;
            r_addr  <= r_idx[LEN_ADDR-1:0];
            r_data  <= w_word_next;
            r_state <= S_WRITE;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        // The write pulse is on the outputs during this cycle; advance the index
        S_WRITE: begin
          r_idx <= w_idx_inc;
          if (w_last_word) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DONE, S_ERR: r_state <= r_state;
        default: r_state <= S_HDR;
      endcase
    end
  end

  assign mem_we_o   = r_we;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_data;
  assign cpu_rst_o  = r_cpu_rst;
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule

// File: tb/tb_insn_loader.sv
// Directed bench for insn_loader: instance A has 256-word depth, instance B 16-word.
module tb_insn_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, use_b = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic valid_i = 1'b0;

  logic stall_a, we_a, cpu_rst_a, done_a, err_a;
  logic [7:0] addr_a;
  logic [31:0] data_a;
  logic stall_b, we_b, cpu_rst_b, done_b, err_b;
  logic [3:0] addr_b;
  logic [31:0] data_b;

  int total = 0, bad = 0;
  logic [7:0]  la_addr[$];
  logic [31:0] la_data[$];
  logic [3:0]  lb_addr[$];
  logic [31:0] lb_data[$];

  insn_loader #(.LEN_INSN(32), .LEN_ADDR(8), .LEN_COUNT(16)) dut_a (
    .clk(clk), .rst(rst_a), .byte_i(byte_i), .valid_i(valid_i), .stall_o(stall_a),
    .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_data_o(data_a),
    .cpu_rst_o(cpu_rst_a), .done_o(done_a), .err_o(err_a));

  insn_loader #(.LEN_INSN(32), .LEN_ADDR(4), .LEN_COUNT(16)) dut_b (
    .clk(clk), .rst(rst_b), .byte_i(byte_i), .valid_i(valid_i), .stall_o(stall_b),
    .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_data_o(data_b),
    .cpu_rst_o(cpu_rst_b), .done_o(done_b), .err_o(err_b));

  always @(negedge clk) begin
    if (we_a === 1'b1) begin la_addr.push_back(addr_a); la_data.push_back(data_a); end
    if (we_b === 1'b1) begin lb_addr.push_back(addr_b); lb_data.push_back(data_b); end
  end

  // Present one byte after `gap` idle cycles; returns at the negedge after acceptance
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin valid_i = 1'b0; byte_i = 8'hEE; @(negedge clk); end
    byte_i = b; valid_i = 1'b1;
    t = 0;
    while ((use_b ? stall_b : stall_a) && t < 20) begin @(negedge clk); t++; end
    if (t == 20) begin
      total++; bad++;
      $display("FAIL send_timeout byte=%h stalled for %0d cycles", b, t);
    end else begin
      @(posedge clk); @(negedge clk);
    end
    valid_i = 1'b0;
  endtask

  task automatic reset_a();
    @(negedge clk); rst_a = 1'b1; valid_i = 1'b0;
    @(negedge clk); rst_a = 1'b0;
    @(negedge clk);
    la_addr = {}; la_data = {};
  endtask

  function automatic logic [31:0] wordb(input int i);
    logic [7:0] v;
    v = 8'(i);
    return {v, ~v, 8'h5A, v + 8'd1};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    total++; if ({we_a, addr_a, data_a} !== 41'd0) begin bad++; $display("FAIL rst_mem got=%b/%h/%h exp=0/00/00000000", we_a, addr_a, data_a); end
    total++; if ({cpu_rst_a, done_a, err_a, stall_a} !== 4'b1001) begin bad++; $display("FAIL rst_flags got=%b exp=1001", {cpu_rst_a, done_a, err_a, stall_a}); end
    rst_a = 1'b0;
    @(negedge clk);
    total++; if ({stall_a, cpu_rst_a} !== 2'b01) begin bad++; $display("FAIL rst_release got=%b exp=01", {stall_a, cpu_rst_a}); end
  endtask

  task automatic test_two_words();
    reset_a();
    send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    total++; if ({we_a, addr_a, data_a, stall_a} !== {1'b1, 8'h00, 32'h12345678, 1'b1}) begin bad++;
      $display("FAIL w0 got we=%b a=%h d=%h st=%b exp 1/00/12345678/1", we_a, addr_a, data_a, stall_a); end
    total++; if ({cpu_rst_a, done_a} !== 2'b10) begin bad++; $display("FAIL w0_flags got=%b exp=10", {cpu_rst_a, done_a}); end
    send(8'h9A, 0); send(8'hBC, 0); send(8'hDE, 0); send(8'hF0, 0);
    total++; if ({we_a, addr_a, data_a} !== {1'b1, 8'h01, 32'h9ABCDEF0}) begin bad++;
      $display("FAIL w1 got we=%b a=%h d=%h exp 1/01/9abcdef0", we_a, addr_a, data_a); end
    @(negedge clk);
    total++; if ({done_a, cpu_rst_a, we_a, stall_a} !== 4'b1001) begin bad++; $display("FAIL two_done got=%b exp=1001", {done_a, cpu_rst_a, we_a, stall_a}); end
    total++; if ({addr_a, data_a} !== {8'h01, 32'h9ABCDEF0}) begin bad++; $display("FAIL two_hold got=%h/%h exp=01/9abcdef0", addr_a, data_a); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (la_addr.size() !== 2) begin bad++; $display("FAIL two_pulses got=%0d exp=2", la_addr.size()); end
  endtask

  task automatic test_count_zero();
    reset_a();
    send(8'h00, 0); send(8'h00, 0);
    total++; if ({done_a, cpu_rst_a, err_a, stall_a} !== 4'b1001) begin bad++; $display("FAIL zero_flags got=%b exp=1001", {done_a, cpu_rst_a, err_a, stall_a}); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (la_addr.size() !== 0) begin bad++; $display("FAIL zero_writes got=%0d exp=0", la_addr.size()); end
  endtask

  task automatic test_too_big();
    logic st;
    reset_a();
    send(8'h01, 0); send(8'h01, 0);
    total++; if ({err_a, cpu_rst_a, stall_a, done_a} !== 4'b1110) begin bad++; $display("FAIL err_flags got=%b exp=1110", {err_a, cpu_rst_a, stall_a, done_a}); end
    st = 1'b1;
    byte_i = 8'h55; valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); st = st & stall_a; end
    valid_i = 1'b0;
    #1;
    total++; if ({st, err_a, cpu_rst_a, we_a} !== 4'b1110) begin bad++; $display("FAIL err_sticky got=%b exp=1110", {st, err_a, cpu_rst_a, we_a}); end
    total++; if (la_addr.size() !== 0) begin bad++; $display("FAIL err_writes got=%0d exp=0", la_addr.size()); end
  endtask

  task automatic test_full_depth();
    logic [31:0] w;
    int errs;
    @(negedge clk); rst_a = 1'b1; use_b = 1'b1;
    rst_b = 1'b1; @(negedge clk); rst_b = 1'b0; @(negedge clk);
    lb_addr = {}; lb_data = {};
    send(8'h00, 0); send(8'h10, 0);
    for (int i = 0; i < 16; i++) begin
      w = wordb(i);
      send(w[31:24], 0); send(w[23:16], 0); send(w[15:8], 0); send(w[7:0], 0);
    end
    total++; if ({we_b, addr_b, data_b} !== {1'b1, 4'hF, wordb(15)}) begin bad++;
      $display("FAIL full_last got we=%b a=%h d=%h exp 1/f/%h", we_b, addr_b, data_b, wordb(15)); end
    @(negedge clk);
    total++; if ({done_b, cpu_rst_b, err_b} !== 3'b100) begin bad++; $display("FAIL full_done got=%b exp=100", {done_b, cpu_rst_b, err_b}); end
    repeat (4) @(negedge clk);
    #1;
    total++; if (lb_addr.size() !== 16) begin bad++; $display("FAIL full_count got=%0d exp=16", lb_addr.size()); end
    errs = 0;
    for (int i = 0; i < lb_addr.size() && i < 16; i++)
      if (lb_addr[i] !== 4'(i) || lb_data[i] !== wordb(i)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL full_seq got=%0d bad entries exp=0", errs); end
    @(negedge clk); rst_b = 1'b1; use_b = 1'b0; rst_a = 1'b0;
  endtask

  task automatic test_gapped();
    logic [7:0] s [10];
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    reset_a();
    for (int i = 0; i < 10; i++) send(s[i], int'($urandom_range(0, 3)));
    @(negedge clk);
    #1;
    total++; if (la_addr.size() !== 2) begin bad++; $display("FAIL gap_count got=%0d exp=2", la_addr.size()); end
    else begin
      total++; if ({la_addr[0], la_data[0], la_addr[1], la_data[1]} !== {8'h00, 32'h12345678, 8'h01, 32'h9ABCDEF0}) begin bad++;
        $display("FAIL gap_data got=%h:%h %h:%h exp 00:12345678 01:9abcdef0", la_addr[0], la_data[0], la_addr[1], la_data[1]); end
    end
    total++; if ({done_a, cpu_rst_a} !== 2'b10) begin bad++; $display("FAIL gap_done got=%b exp=10", {done_a, cpu_rst_a}); end
  endtask

  task automatic test_mid_reset();
    reset_a();
    send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    send(8'h9A, 0); send(8'hBC, 0);
    rst_a = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    total++; if ({cpu_rst_a, done_a, we_a, stall_a} !== 4'b1001) begin bad++; $display("FAIL mid_in_rst got=%b exp=1001", {cpu_rst_a, done_a, we_a, stall_a}); end
    total++; if ({addr_a, data_a} !== 40'd0) begin bad++; $display("FAIL mid_rst_out got=%h/%h exp=00/00000000", addr_a, data_a); end
    rst_a = 1'b0;
    @(negedge clk);
    total++; if ({cpu_rst_a, done_a, we_a, stall_a} !== 4'b1000) begin bad++; $display("FAIL mid_after got=%b exp=1000", {cpu_rst_a, done_a, we_a, stall_a}); end
    la_addr = {}; la_data = {};
    send(8'h00, 0); send(8'h01, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    total++; if ({we_a, addr_a, data_a} !== {1'b1, 8'h00, 32'hAABBCCDD}) begin bad++;
      $display("FAIL mid_fresh got we=%b a=%h d=%h exp 1/00/aabbccdd", we_a, addr_a, data_a); end
    @(negedge clk);
    total++; if ({done_a, cpu_rst_a} !== 2'b10) begin bad++; $display("FAIL mid_done got=%b exp=10", {done_a, cpu_rst_a}); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_count_zero();
    test_too_big();
    test_full_depth();
    test_gapped();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
